// File: rtl/hsmc_tx_serializer.sv
// Four-lane HSMC transmit serializer: one 32-bit word per 8*BIT_DIV-cycle frame, IDLE_BYTE fill on underrun.
// Optional post-reset training sequence (TRAIN_FRAMES frames of 8'hA5) is built only when HSMC_TX_TRAINING_EN is defined.
module hsmc_tx_serializer #(
    parameter int unsigned BIT_DIV      = 4,
    parameter logic [7:0]  IDLE_BYTE    = 8'hBC,
    parameter int unsigned TRAIN_FRAMES = 16
) (
    input  logic        OSC_50_B8A,
    input  logic        RESET_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [3:0]  HSMC_TX_p,
    output logic        frame_start,
    output logic [7:0]  underrun_cnt
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIV_W  = 8;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BIT_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
`ifdef HSMC_TX_TRAINING_EN
    localparam logic [1:0]        ST_TRAIN    = 2'd0;
    localparam logic [BYTE_W-1:0] TRAIN_BYTE  = 8'hA5;
    localparam logic [7:0]        TRAIN_LAST  = 8'(TRAIN_FRAMES - 1);
    localparam logic [BYTE_W-1:0] FIRST_BYTE  = TRAIN_BYTE;
    localparam logic [1:0]        RESET_STATE = ST_TRAIN;
`else
    localparam logic [BYTE_W-1:0] FIRST_BYTE  = IDLE_BYTE;
    localparam logic [1:0]        RESET_STATE = ST_IDLE;
`endif

    if (BIT_DIV < 1 || BIT_DIV > 255 || TRAIN_FRAMES < 1 || TRAIN_FRAMES > 255) begin : g_bad_params
        $error("hsmc_tx_serializer: BIT_DIV and TRAIN_FRAMES must lie in 1..255");
    end

    logic [DIV_W-1:0]                  div_cnt;
    logic [2:0]                        bit_idx;
    logic [LANES-1:0][BYTE_W-1:0]      shift;
    logic [LANES-1:0][BYTE_W-1:0]      shift_nxt;
    logic [LANES-1:0][BYTE_W-1:0]      hold_reg;
    logic                              hold_full;
    logic                              hold_full_nxt;
    logic                              ready_nxt;
    logic [1:0]                        state;
    logic [1:0]                        state_nxt;
    logic                              seen_data;
    logic                              seen_nxt;
    logic [7:0]                        under_nxt;
    logic                              started;
    logic                              bit_tick;
    logic                              boundary;
    logic                              accept;
`ifdef HSMC_TX_TRAINING_EN
    logic [7:0]                        train_left;
    logic [7:0]                        train_left_nxt;
`endif

    assign bit_tick = (div_cnt == '0);
    assign boundary = bit_tick && (bit_idx == 3'd7);
    assign accept   = data_valid && data_ready;

    // Lane outputs are the MSB of each lane's shift register.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            HSMC_TX_p[i] = shift[i][BYTE_W-1];
        end
    end

    // Next-state: frame loads at boundaries, shifting on other bit ticks, buffer and counters.
    always_comb begin
        shift_nxt     = shift;
        hold_full_nxt = hold_full;
        state_nxt     = state;
        seen_nxt      = seen_data;
        under_nxt     = underrun_cnt;
`ifdef HSMC_TX_TRAINING_EN
        train_left_nxt = train_left;
`endif
        if (accept) begin
            hold_full_nxt = 1'b1;
        end
        if (boundary) begin
            if (state == ST_DATA) begin
                seen_nxt = 1'b1;
            end
`ifdef HSMC_TX_TRAINING_EN
            if (state == ST_TRAIN && train_left != 8'd0) begin
                shift_nxt      = {LANES{TRAIN_BYTE}};
                train_left_nxt = train_left - 8'd1;
            end else
`endif
            if (hold_full) begin
                shift_nxt     = hold_reg;
                hold_full_nxt = 1'b0;
                state_nxt     = ST_DATA;
            end else begin
                shift_nxt = {LANES{IDLE_BYTE}};
                state_nxt = ST_IDLE;
                if ((seen_data || state == ST_DATA) && underrun_cnt != 8'hFF) begin
                    under_nxt = underrun_cnt + 8'd1;
                end
            end
        end else if (bit_tick) begin
            for (int i = 0; i < int'(LANES); i++) begin
                shift_nxt[i] = {shift[i][BYTE_W-2:0], 1'b0};
            end
        end
`ifdef HSMC_TX_TRAINING_EN
        ready_nxt = (state_nxt != ST_TRAIN) && !hold_full_nxt;
`else
        ready_nxt = !hold_full_nxt;
`endif
    end

    // State register.
    always_ff @(posedge OSC_50_B8A or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge OSC_50_B8A or negedge RESET_n) begin
        if (!RESET_n) begin
            div_cnt      <= DIV_RELOAD;
            bit_idx      <= 3'd0;
            shift        <= {LANES{FIRST_BYTE}};
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            data_ready   <= 1'b0;
            seen_data    <= 1'b0;
            underrun_cnt <= 8'd0;
            frame_start  <= 1'b0;
            started      <= 1'b0;
`ifdef HSMC_TX_TRAINING_EN
            train_left   <= TRAIN_LAST;
`endif
        end else begin
            div_cnt      <= bit_tick ? DIV_RELOAD : div_cnt - DIV_W'(1);
            if (bit_tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (accept) begin
                hold_reg <= data_in;
            end
            shift        <= shift_nxt;
            hold_full    <= hold_full_nxt;
            data_ready   <= ready_nxt;
            seen_data    <= seen_nxt;
            underrun_cnt <= under_nxt;
            frame_start  <= boundary || !started;
            started      <= 1'b1;
`ifdef HSMC_TX_TRAINING_EN
            train_left   <= train_left_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_hsmc_tx_serializer.sv
// Self-checking bench for hsmc_tx_serializer: random and directed traffic against a frame-level reference model.
module tb_hsmc_tx_serializer;

    localparam int unsigned BD = 4;
    localparam int unsigned TF = 2;
    localparam int          F  = 8 * BD;
    localparam logic [7:0]  IDLE = 8'hBC;
`ifdef HSMC_TX_TRAINING_EN
    localparam logic [7:0]  FIRST = 8'hA5;
`else
    localparam logic [7:0]  FIRST = IDLE;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  tx;
    logic        frame_start;
    logic [7:0]  underrun_cnt;

    hsmc_tx_serializer #(
        .BIT_DIV      (BD),
        .IDLE_BYTE    (IDLE),
        .TRAIN_FRAMES (TF)
    ) dut (
        .OSC_50_B8A   (clk),
        .RESET_n      (rst_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .HSMC_TX_p    (tx),
        .frame_start  (frame_start),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycle index since reset release and the frame currently on the wire.
    int          c;
    logic [31:0] m_frame;
    logic [31:0] m_hold;
    bit          m_full;
    bit          m_sent;
    int          m_under;
    logic [31:0] word_q[$];
    bit          shot_armed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, c, $time);
        end
    endtask

    function automatic logic exp_ready();
`ifdef HSMC_TX_TRAINING_EN
        return (c >= 1) && (c >= int'(TF) * F) && !m_full;
`else
        return (c >= 1) && !m_full;
`endif
    endfunction

    task automatic check_outputs();
        int         j;
        logic [3:0] eb;
        logic       fs;
        j = (c % F) / int'(BD);
        for (int i = 0; i < 4; i++) begin
            eb[i] = m_frame[8*i + 7 - j];
        end
        fs = (c == 1) || (c > 0 && (c % F) == 0);
        check("lanes", 32'(tx), 32'(eb));
        check("frame_start", 32'(frame_start), 32'(fs));
        check("data_ready", 32'(data_ready), 32'(exp_ready()));
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
    endtask

    task automatic check_reset_values();
        check("rst_lanes", 32'(tx), 32'h0000000F);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_data_ready", 32'(data_ready), 32'h0);
        check("rst_underrun_cnt", 32'(underrun_cnt), 32'h0);
    endtask

    // Advance the model across one rising edge that ends cycle c.
    task automatic model_edge(input logic v, input logic [31:0] d);
        logic acc;
        int   k_next;
        acc = v && exp_ready();
        if (((c + 1) % F) == 0) begin
            k_next = (c + 1) / F;
`ifdef HSMC_TX_TRAINING_EN
            if (k_next < int'(TF)) begin
                m_frame = {4{8'hA5}};
            end else
`endif
            if (m_full) begin
                m_frame = m_hold;
                m_full  = 1'b0;
                m_sent  = 1'b1;
            end else begin
                m_frame = {4{IDLE}};
                if (m_sent && m_under < 255) m_under++;
            end
        end
        if (acc) begin
            m_hold = d;
            m_full = 1'b1;
        end
        c++;
    endtask

    // Modes: 0 idle, 1 stream word_q, 2 random, 3 single word in a boundary cycle.
    task automatic run(input int n, input int mode);
        logic acc;
        for (int k = 0; k < n; k++) begin
            case (mode)
                1: begin
                    if (word_q.size() > 0) begin
                        data_valid = 1'b1;
                        data_in    = word_q[0];
                    end else begin
                        data_valid = 1'b0;
                    end
                end
                2: begin
                    data_valid = 1'($urandom_range(0, 1));
                    data_in    = $urandom();
                end
                3: begin
                    if (shot_armed && ((c + 1) % F) == 0 && exp_ready()) begin
                        data_valid = 1'b1;
                        data_in    = $urandom();
                        shot_armed = 1'b0;
                    end else begin
                        data_valid = 1'b0;
                    end
                end
                default: data_valid = 1'b0;
            endcase
            check_outputs();
            acc = data_valid && exp_ready();
            @(posedge clk);
            model_edge(data_valid, data_in);
            if (mode == 1 && acc) void'(word_q.pop_front());
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n      = 1'b1;
        c          = 0;
        m_frame    = {4{FIRST}};
        m_hold     = '0;
        m_full     = 1'b0;
        m_sent     = 1'b0;
        m_under    = 0;
        data_valid = 1'b0;
        word_q.delete();
    endtask

    initial begin
        rst_n      = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        shot_armed = 1'b0;
        c          = 0;
        @(negedge clk);
        do_reset();

        // Idle line after reset.
        run(64, 0);
        check("underrun_idle_only", 32'(underrun_cnt), 32'h0);

        // Single word, then idle.
        word_q.push_back(32'h12345678);
        run(2 * F, 1);
        check("underrun_after_one_word", 32'(underrun_cnt), 32'h1);
        run(F, 0);

        // Back-to-back words with valid held high.
        word_q.push_back(32'hA1B2C3D4);
        word_q.push_back(32'h0F1E2D3C);
        word_q.push_back(32'hDEADBEEF);
        run(5 * F, 1);
        check("stream_drained", 32'(word_q.size()), 32'h0);

        // Word offered only in the boundary cycle with the buffer empty.
        shot_armed = 1'b1;
        run(3 * F, 3);
        check("boundary_shot_taken", 32'(shot_armed), 32'h0);

        // Random traffic.
        run(60 * F, 2);
        run(F, 0);

        // Long underrun saturates.
        run(300 * F, 0);
        check("underrun_saturated", 32'(underrun_cnt), 32'd255);

        // Reset mid-frame with a word buffered.
        word_q.push_back(32'h55AA33CC);
        run(F / 2 + 3, 1);
        do_reset();
        run(4 * F, 0);
        check("underrun_after_reset", 32'(underrun_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
